// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch engine: FSM state encoding, the
// fixed digit modulus pattern, the decimal-point mask and the 7-seg encoder.
package stopwatch_pkg;

  // FSM state encoding, kept as plain localparams for legacy compatibility
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_LAP   = 2'd3;

  localparam int MAX_DIGITS = 8;

  // Modulus of each time digit, digit 0 first: 10ms,100ms,1s,10s,1m,10m,1h,10h
  localparam int DIGIT_MOD [MAX_DIGITS] = '{10, 10, 10, 6, 10, 6, 10, 10};

  // Decimal point per digit position, active-low: lit on digits 2, 4 and 6
  localparam logic [MAX_DIGITS-1:0] DP_MASK = 8'hAB;

  // Hex to active-low 7-seg, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sw_digit_cell.sv
// One mod-M BCD time digit. carry flags the terminal value so the parent
// can build the ripple-enable chain without knowing each digit's modulus.
module sw_digit_cell
  import stopwatch_pkg::*;
#(
  parameter int M = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = (q == 4'(M - 1));

  // Digit register: synchronous clear wins over increment, wrap at M-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= carry ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: run/pause/lap/clear FSM, tick prescaler, cascaded time
// digits, lap snapshot register and a free-running 7-seg display scanner.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 8,
  parameter int WRAP       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEG,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    running,
  output logic                    overflow
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int SDIV = CLK_HZ / SCAN_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SPW  = (SDIV > 1) ? $clog2(SDIV) : 1;

  state_t                  state, next_state;
  logic [PW-1:0]           presc;
  logic [SPW-1:0]          spresc;
  logic [2:0]              idx;
  logic                    active, tick, full, hold_max, do_clear, spulse;
  logic [NUM_DIGITS:0]     chain;
  logic [NUM_DIGITS-1:0]   carry, inc;
  logic [3:0]              dq [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] live;
  logic [3:0]              nib [MAX_DIGITS];

  assign active   = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = active && (presc == PW'(DIV - 1));
  assign full     = tick && chain[NUM_DIGITS];
  assign hold_max = full && (WRAP == 0);
  assign do_clear = (state == ST_PAUSE) && clear;
  assign spulse   = (spresc == SPW'(SDIV - 1));
  assign chain[0] = 1'b1;

  // Next state: clear > start_stop > lap, only pulses valid in the state act;
  // a saturating full count forces PAUSE regardless of pulses
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start_stop) next_state = ST_RUN;
      ST_RUN:   if (hold_max || start_stop) next_state = ST_PAUSE;
                else if (lap) next_state = ST_LAP;
      ST_LAP:   if (hold_max || start_stop) next_state = ST_PAUSE;
                else if (lap) next_state = ST_RUN;
      default:  if (clear) next_state = ST_IDLE;
                else if (start_stop) next_state = ST_RUN;
    endcase
  end

  // State register plus registered running flag derived from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == ST_RUN) || (next_state == ST_LAP);
    end
  end

  // Tick prescaler: advances only while counting, holds in PAUSE for exact resume
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (do_clear) begin
      presc <= '0;
    end else if (active) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Sticky full-count flag, only dropped by clear from PAUSE or reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (do_clear) begin
      overflow <= 1'b0;
    end else if (full) begin
      overflow <= 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign chain[g+1]     = chain[g] & carry[g];
      assign inc[g]         = tick && chain[g] && !hold_max;
      assign live[4*g +: 4] = dq[g];
      sw_digit_cell #(.M(DIGIT_MOD[g])) u_cell (
        .clk   (clk),
        .reset (reset),
        .clr   (do_clear),
        .inc   (inc[g]),
        .q     (dq[g]),
        .carry (carry[g])
      );
    end
    for (g = 0; g < MAX_DIGITS; g++) begin : g_nib
      if (g < NUM_DIGITS) begin : g_used
        assign nib[g] = bcd_out[4*g +: 4];
      end else begin : g_pad
        assign nib[g] = 4'd0;
      end
    end
  endgenerate

  // Display value: follows the live count except while a lap snapshot is shown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_out <= '0;
    end else if (state != ST_LAP) begin
      bcd_out <= live;
    end
  end

  // Scanner: own prescaler, digit index and registered AN/SEG updated together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spresc <= '0;
      idx    <= 3'd0;
      AN     <= '1;
      SEG    <= 8'hFF;
    end else if (spulse) begin
      spresc <= '0;
      idx    <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      AN     <= ~(NUM_DIGITS'(1) << idx);
      SEG    <= {DP_MASK[idx], seg7(nib[idx])};
    end else begin
      spresc <= spresc + SPW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: an 8-digit wrapping instance plus two
// 4-digit instances (saturating and wrapping) sharing the same stimulus.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;

  logic [7:0]  an8, seg8;
  logic [31:0] bcd8;
  logic        run8, ovf8;
  logic [3:0]  an4s, an4w;
  logic [7:0]  seg4s, seg4w;
  logic [15:0] bcd4s, bcd4w;
  logic        run4s, ovf4s, run4w, ovf4w;

  int vectors = 0;
  int miscompares = 0;

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(500), .NUM_DIGITS(8), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .AN(an8), .SEG(seg8), .bcd_out(bcd8), .running(run8), .overflow(ovf8));

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(500), .NUM_DIGITS(4), .WRAP(0)) dut4s (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .AN(an4s), .SEG(seg4s), .bcd_out(bcd4s), .running(run4s), .overflow(ovf4s));

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(500), .NUM_DIGITS(4), .WRAP(1)) dut4w (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .AN(an4w), .SEG(seg4w), .bcd_out(bcd4w), .running(run4w), .overflow(ovf4w));

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the given pulses for exactly one active edge
  task automatic pulse(input logic s, input logic c, input logic l);
    start_stop = s; clear = c; lap = l;
    step(1);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    vectors++; if (an8 !== 8'hFF) begin miscompares++; $display("[TB] FAIL reset_an got=%h want=ff", an8); end
    vectors++; if (seg8 !== 8'hFF) begin miscompares++; $display("[TB] FAIL reset_seg got=%h want=ff", seg8); end
    vectors++; if (bcd8 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_bcd got=%h want=0", bcd8); end
    vectors++; if (run8 !== 1'b0 || ovf8 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags got=%b%b want=00", run8, ovf8); end
    step(1);
    vectors++; if (an8 !== 8'hFF) begin miscompares++; $display("[TB] FAIL scan_pre got=%h want=ff", an8); end
    step(1);
    vectors++; if (an8 !== 8'hFE) begin miscompares++; $display("[TB] FAIL scan0_an got=%h want=fe", an8); end
    vectors++; if (seg8 !== 8'hC0) begin miscompares++; $display("[TB] FAIL scan0_seg got=%h want=c0", seg8); end
    step(2);
    vectors++; if (an8 !== 8'hFD) begin miscompares++; $display("[TB] FAIL scan1_an got=%h want=fd", an8); end
    step(2);
    vectors++; if (an8 !== 8'hFB) begin miscompares++; $display("[TB] FAIL scan2_an got=%h want=fb", an8); end
    vectors++; if (seg8 !== 8'h40) begin miscompares++; $display("[TB] FAIL scan2_dp got=%h want=40", seg8); end
  endtask

  task automatic test_count_pause();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    vectors++; if (run8 !== 1'b1) begin miscompares++; $display("[TB] FAIL run_rise got=%b want=1", run8); end
    step(251);
    vectors++; if (bcd8[7:0] !== 8'h25) begin miscompares++; $display("[TB] FAIL count250 got=%h want=25", bcd8[7:0]); end
    step(2);
    pulse(1'b1, 1'b0, 1'b0);
    vectors++; if (run8 !== 1'b0) begin miscompares++; $display("[TB] FAIL pause_run got=%b want=0", run8); end
    step(100);
    vectors++; if (bcd8[7:0] !== 8'h25) begin miscompares++; $display("[TB] FAIL pause_hold got=%h want=25", bcd8[7:0]); end
    pulse(1'b1, 1'b0, 1'b0);
    vectors++; if (run8 !== 1'b1) begin miscompares++; $display("[TB] FAIL resume_run got=%b want=1", run8); end
    step(6);
    vectors++; if (bcd8[7:0] !== 8'h25) begin miscompares++; $display("[TB] FAIL resume_early got=%h want=25", bcd8[7:0]); end
    step(1);
    vectors++; if (bcd8[7:0] !== 8'h26) begin miscompares++; $display("[TB] FAIL resume_tick got=%h want=26", bcd8[7:0]); end
  endtask

  task automatic test_lap();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    step(124);
    pulse(1'b0, 1'b0, 1'b1);
    vectors++; if (bcd8[7:0] !== 8'h12) begin miscompares++; $display("[TB] FAIL lap_capture got=%h want=12", bcd8[7:0]); end
    step(175);
    vectors++; if (bcd8[7:0] !== 8'h12) begin miscompares++; $display("[TB] FAIL lap_frozen got=%h want=12", bcd8[7:0]); end
    vectors++; if (run8 !== 1'b1) begin miscompares++; $display("[TB] FAIL lap_running got=%b want=1", run8); end
    step(124);
    pulse(1'b0, 1'b0, 1'b1);
    step(1);
    vectors++; if (bcd8[7:0] !== 8'h42) begin miscompares++; $display("[TB] FAIL lap_release got=%h want=42", bcd8[7:0]); end
    vectors++; if (run8 !== 1'b1) begin miscompares++; $display("[TB] FAIL lap_run_after got=%b want=1", run8); end
  endtask

  task automatic test_priority();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    step(34);
    pulse(1'b1, 1'b1, 1'b0);
    step(1);
    vectors++; if (run8 !== 1'b0) begin miscompares++; $display("[TB] FAIL run_clr_ignored got=%b want=0", run8); end
    vectors++; if (bcd8[7:0] !== 8'h03) begin miscompares++; $display("[TB] FAIL run_clr_value got=%h want=03", bcd8[7:0]); end
    pulse(1'b1, 1'b1, 1'b0);
    step(1);
    vectors++; if (bcd8 !== 32'h0) begin miscompares++; $display("[TB] FAIL pause_clr_value got=%h want=0", bcd8); end
    step(20);
    vectors++; if (run8 !== 1'b0 || bcd8 !== 32'h0) begin miscompares++; $display("[TB] FAIL idle_after_clr got=%b/%h want=0/0", run8, bcd8); end
  endtask

  task automatic test_cascade_fullcount();
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    step(59991);
    vectors++; if (bcd8 !== 32'h0000_5999) begin miscompares++; $display("[TB] FAIL at_5999 got=%h want=00005999", bcd8); end
    vectors++; if (bcd4s !== 16'h5999 || ovf4s !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_pre got=%h/%b want=5999/0", bcd4s, ovf4s); end
    step(10);
    vectors++; if (bcd8 !== 32'h0001_0000) begin miscompares++; $display("[TB] FAIL cascade got=%h want=00010000", bcd8); end
    vectors++; if (ovf8 !== 1'b0) begin miscompares++; $display("[TB] FAIL cascade_ovf got=%b want=0", ovf8); end
    vectors++; if (bcd4s !== 16'h5999) begin miscompares++; $display("[TB] FAIL sat_hold got=%h want=5999", bcd4s); end
    vectors++; if (run4s !== 1'b0 || ovf4s !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_flags got=%b%b want=01", run4s, ovf4s); end
    vectors++; if (bcd4w !== 16'h0000) begin miscompares++; $display("[TB] FAIL wrap_value got=%h want=0000", bcd4w); end
    vectors++; if (run4w !== 1'b1 || ovf4w !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_flags got=%b%b want=11", run4w, ovf4w); end
    pulse(1'b0, 1'b1, 1'b0);
    step(1);
    vectors++; if (bcd4s !== 16'h0 || ovf4s !== 1'b0 || run4s !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_clear got=%h/%b/%b want=0/0/0", bcd4s, ovf4s, run4s); end
    vectors++; if (ovf4w !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_ovf_sticky got=%b want=1", ovf4w); end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b0;
    #1;
    vectors++; if (an8 !== 8'hFF || seg8 !== 8'hFF) begin miscompares++; $display("[TB] FAIL async_display got=%h/%h want=ff/ff", an8, seg8); end
    vectors++; if (bcd8 !== 32'h0 || run8 !== 1'b0) begin miscompares++; $display("[TB] FAIL async_count got=%h/%b want=0/0", bcd8, run8); end
    vectors++; if (ovf4w !== 1'b0) begin miscompares++; $display("[TB] FAIL async_ovf got=%b want=0", ovf4w); end
    step(2);
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_count_pause();
    test_lap();
    test_priority();
    test_cascade_fullcount();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
